imi_mixer: RTL
==============

IMI_MIXER -- requirements
Module: imi_mixer

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of summed channels, 1..64.
REQ-002 SHALL have parameter CH_WIDTH, default 8: signed width of each channel sample.
REQ-003 SHALL have parameter AWGN_WIDTH, default 10: signed width of raw noise input.
REQ-004 SHALL have parameter NGAIN_WIDTH, default 8: unsigned noise gain width.
REQ-005 SHALL have parameter OUT_WIDTH, default 8: signed output width.
REQ-006 SHALL have parameter PERIOD_2N, default 15: clip-count window = 2^PERIOD_2N valid samples.
REQ-007 SHALL have ports: clk  in  1  clock; resetn  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports: in_valid  in  1  input sample strobe; i_in, q_in  in  N_CH*CH_WIDTH  packed channel samples, channel 0 in LSBs.
REQ-009 SHALL have ports: awgn_i, awgn_q  in  AWGN_WIDTH  signed noise; noise_gain  in  NGAIN_WIDTH  noise multiplier.
REQ-010 SHALL have ports: mode  in  2  output mode; out_shift  in  5  arithmetic right shift.
REQ-011 SHALL have ports: i_out, q_out  out  OUT_WIDTH  signed result; out_valid  out  1.
REQ-012 SHALL have ports: clip_cnt  out  PERIOD_2N+1  clipped samples in last window; clip_cnt_valid  out  1  one-cycle pulse.

Function
REQ-013 SHALL define SUM_W = CH_WIDTH+clog2(N_CH), NOISE_W = AWGN_WIDTH+NGAIN_WIDTH+1, FULL_W = max(SUM_W,NOISE_W)+1; no internal overflow before the limiter.
REQ-014 SHALL advance the pipeline every cycle, carrying in_valid as a valid bit; bubbles propagate unchanged.
REQ-015 SHALL capture mode, out_shift, noise_gain with each sample at stage 1; they travel with that sample, so a config change never affects samples already in flight.
REQ-016 Stage group A: pipelined adder tree over N_CH channels, latency SUM_LAT = max(1, clog2(N_CH)); noise product awgn*noise_gain (gain treated unsigned) delay-matched to the sum.
REQ-017 Stage B (1 cycle): mix per mode: 0 = sum; 1 = sum+noise; 2 = sum+noise, sign-reduced later; 3 = noise only.
REQ-018 Stage C (1 cycle): arithmetic right shift by out_shift, rounded toward zero (add 1 when value negative and any discarded bit set); out_shift >= FULL_W-1 treated as FULL_W-1.
REQ-019 Stage D (1 cycle): saturate to [-(2^(OUT_WIDTH-1)-1), 2^(OUT_WIDTH-1)-1] (symmetric); set clip flag when I or Q saturates.
REQ-020 Mode 2 SHALL output +1 when pre-shift mix > 0, else -1 (zero maps to -1); no clipping in mode 2.
REQ-021 Total latency in_valid -> out_valid SHALL be L = SUM_LAT+3 cycles; i_out/q_out hold their value when out_valid = 0.
REQ-022 Clip counter SHALL count valid samples with clip flag; window counter counts valid outputs.
REQ-023 On the 2^PERIOD_2N-th valid output: clip_cnt <= count including that sample, clip_cnt_valid pulses 1 cycle, both counters restart from 0 next cycle.
REQ-024 Clip counter SHALL saturate at its maximum and not wrap.

Reset
REQ-025 resetn low SHALL asynchronously clear all pipeline data and valid bits, i_out, q_out, out_valid, clip_cnt, clip_cnt_valid, and both counters to 0.
REQ-026 Reset mid-window SHALL discard partial counts; first window after reset is a full 2^PERIOD_2N valid samples.
REQ-027 After resetn deasserts, out_valid SHALL stay 0 until L cycles after the first in_valid.

Verification (N_CH=4, CH_WIDTH=8, OUT_WIDTH=8, PERIOD_2N=3 unless noted)
REQ-028 Reset asserted mid-stream -> all outputs 0 same cycle; out_valid 0 until L=5 cycles after next in_valid.
REQ-029 mode 0, shift 0, I channels {10,20,-5,3}, single valid -> i_out=28, out_valid high exactly 5 cycles later, one cycle.
REQ-030 mode 0, shift 2, sums -7 then 7 -> i_out -1 then 1; sum -8 -> -2.
REQ-031 mode 0, all channels 127 -> i_out 127, clip flagged; all -128 -> -127.
REQ-032 mode 2, sum 3, awgn -3, gain 1 -> i_out -1; awgn -2 -> +1; mode switched 1->2 mid-stream affects only samples entering after switch.
REQ-033 8 consecutive valid samples, 3 clipped (incl. 8th) -> clip_cnt=3, clip_cnt_valid one pulse; next window with none clipped -> clip_cnt=0.

Source files
------------

// File: rtl/imi_mixer.sv
// Purpose: sums N_CH I/Q channels, mixes in gain-scaled noise, shifts, saturates and counts clips.
// Latency: SUM_LAT+3 cycles from in_valid to out_valid (SUM_LAT = max(1, clog2(N_CH))).
// Backpressure: none; the pipeline advances every cycle and bubbles flow through unchanged.
module imi_mixer #(
    parameter int N_CH        = 4,
    parameter int CH_WIDTH    = 8,
    parameter int AWGN_WIDTH  = 10,
    parameter int NGAIN_WIDTH = 8,
    parameter int OUT_WIDTH   = 8,
    parameter int PERIOD_2N   = 15
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         in_valid,
    input  logic [N_CH*CH_WIDTH-1:0]     i_in,
    input  logic [N_CH*CH_WIDTH-1:0]     q_in,
    input  logic [AWGN_WIDTH-1:0]        awgn_i,
    input  logic [AWGN_WIDTH-1:0]        awgn_q,
    input  logic [NGAIN_WIDTH-1:0]       noise_gain,
    input  logic [1:0]                   mode,
    input  logic [4:0]                   out_shift,
    output logic [OUT_WIDTH-1:0]         i_out,
    output logic [OUT_WIDTH-1:0]         q_out,
    output logic                         out_valid,
    output logic [PERIOD_2N:0]           clip_cnt,
    output logic                         clip_cnt_valid
);

    localparam int LOG_N   = (N_CH > 1) ? $clog2(N_CH) : 0;
    localparam int NP      = 1 << LOG_N;
    localparam int SUM_W   = CH_WIDTH + LOG_N;
    localparam int NOISE_W = AWGN_WIDTH + NGAIN_WIDTH + 1;
    localparam int FULL_W  = ((SUM_W > NOISE_W) ? SUM_W : NOISE_W) + 1;
    localparam int SUM_LAT = (LOG_N > 1) ? LOG_N : 1;
    localparam int CMP_W   = ((FULL_W > OUT_WIDTH) ? FULL_W : OUT_WIDTH) + 1;

    localparam logic signed [CMP_W-1:0]     SAT_MAX   = CMP_W'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [CMP_W-1:0]     SAT_MIN   = -SAT_MAX;
    localparam logic signed [OUT_WIDTH-1:0] SAT_MAX_O = OUT_WIDTH'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [OUT_WIDTH-1:0] SAT_MIN_O = -SAT_MAX_O;
    localparam logic signed [FULL_W-1:0]    POS_ONE   = FULL_W'(1);
    localparam logic signed [FULL_W-1:0]    NEG_ONE   = '1;
    localparam logic [PERIOD_2N-1:0]        WIN_LAST  = '1;
    localparam logic [PERIOD_2N:0]          ACC_MAX   = '1;

    // Sideband that rides alongside the adder tree: valid, per-sample config, noise products.
    typedef struct packed {
        logic                      vld;
        logic [1:0]                mode;
        logic [4:0]                shift;
        logic signed [NOISE_W-1:0] ni;
        logic signed [NOISE_W-1:0] nq;
    } side_t;

    // ---------------- stage 1 inputs: leaves and noise products ----------------
    logic signed [SUM_W-1:0]   leaf_i [NP];
    logic signed [SUM_W-1:0]   leaf_q [NP];
    logic signed [NOISE_W-1:0] awgn_i_ext, awgn_q_ext, gain_ext;
    logic signed [NOISE_W-1:0] prod_i, prod_q;

    for (genvar j = 0; j < NP; j++) begin : g_leaf
        if (j < N_CH) begin : g_real
            assign leaf_i[j] = SUM_W'($signed(i_in[j*CH_WIDTH +: CH_WIDTH]));
            assign leaf_q[j] = SUM_W'($signed(q_in[j*CH_WIDTH +: CH_WIDTH]));
        end else begin : g_pad
            assign leaf_i[j] = '0;
            assign leaf_q[j] = '0;
        end
    end

    // Gain is unsigned: zero-extend it so the signed multiply never sees it as negative.
    assign awgn_i_ext = NOISE_W'($signed(awgn_i));
    assign awgn_q_ext = NOISE_W'($signed(awgn_q));
    assign gain_ext   = NOISE_W'(noise_gain);
    assign prod_i     = awgn_i_ext * gain_ext;
    assign prod_q     = awgn_q_ext * gain_ext;

    // ---------------- stage group A: adder tree ----------------
    logic signed [SUM_W-1:0] root_i, root_q;

    if (NP == 1) begin : g_single
        logic signed [SUM_W-1:0] reg_i_q, reg_q_q;
        // Single channel: one register stage keeps the minimum tree latency of 1.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                reg_i_q <= '0;
                reg_q_q <= '0;
            end else begin
                reg_i_q <= leaf_i[0];
                reg_q_q <= leaf_q[0];
            end
        end
        assign root_i = reg_i_q;
        assign root_q = reg_q_q;
    end else begin : g_tree
        // Heap-ordered internal nodes: node k has children 2k+1 and 2k+2; indices >= NP-1 are leaves.
        logic signed [SUM_W-1:0] node_i_q [NP-1];
        logic signed [SUM_W-1:0] node_q_q [NP-1];
        for (genvar k = 0; k < NP-1; k++) begin : g_node
            if (2*k+1 >= NP-1) begin : g_bottom
                // Bottom level adds two leaves straight from the input ports.
                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) begin
                        node_i_q[k] <= '0;
                        node_q_q[k] <= '0;
                    end else begin
                        node_i_q[k] <= leaf_i[2*k+1-(NP-1)] + leaf_i[2*k+2-(NP-1)];
                        node_q_q[k] <= leaf_q[2*k+1-(NP-1)] + leaf_q[2*k+2-(NP-1)];
                    end
                end
            end else begin : g_inner
                // Upper levels add two registered partial sums.
                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) begin
                        node_i_q[k] <= '0;
                        node_q_q[k] <= '0;
                    end else begin
                        node_i_q[k] <= node_i_q[2*k+1] + node_i_q[2*k+2];
                        node_q_q[k] <= node_q_q[2*k+1] + node_q_q[2*k+2];
                    end
                end
            end
        end
        assign root_i = node_i_q[0];
        assign root_q = node_q_q[0];
    end

    side_t side_d;
    side_t side_q [1:SUM_LAT];

    assign side_d = '{vld: in_valid, mode: mode, shift: out_shift, ni: prod_i, nq: prod_q};

    // Sideband delay line matched to the adder tree depth.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 1; k <= SUM_LAT; k++) side_q[k] <= '0;
        end else begin
            side_q[1] <= side_d;
            for (int k = 2; k <= SUM_LAT; k++) side_q[k] <= side_q[k-1];
        end
    end

    // ---------------- stage B: mix ----------------
    function automatic logic signed [FULL_W-1:0] mix_fn(input logic [1:0] md,
                                                        input logic signed [SUM_W-1:0] s,
                                                        input logic signed [NOISE_W-1:0] n);
        logic signed [FULL_W-1:0] sf, nf;
        sf = FULL_W'(s);
        nf = FULL_W'(n);
        case (md)
            2'd0:    return sf;
            2'd3:    return nf;
            default: return sf + nf;
        endcase
    endfunction

    logic                     vld_b_q, sgn_b_q;
    logic [4:0]               shift_b_q;
    logic signed [FULL_W-1:0] mix_i_q, mix_q_q;

    // Mix register; mode 2 is remembered as a sign-only flag for the next stages.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_b_q   <= 1'b0;
            sgn_b_q   <= 1'b0;
            shift_b_q <= '0;
            mix_i_q   <= '0;
            mix_q_q   <= '0;
        end else begin
            vld_b_q   <= side_q[SUM_LAT].vld;
            sgn_b_q   <= (side_q[SUM_LAT].mode == 2'd2);
            shift_b_q <= side_q[SUM_LAT].shift;
            mix_i_q   <= mix_fn(side_q[SUM_LAT].mode, root_i, side_q[SUM_LAT].ni);
            mix_q_q   <= mix_fn(side_q[SUM_LAT].mode, root_q, side_q[SUM_LAT].nq);
        end
    end

    // ---------------- stage C: shift toward zero / sign reduce ----------------
    function automatic logic signed [FULL_W-1:0] shr_rtz(input logic signed [FULL_W-1:0] v,
                                                         input int unsigned sh);
        logic [FULL_W-1:0]        mask;
        logic signed [FULL_W-1:0] r;
        mask = ~({FULL_W{1'b1}} << sh);
        r    = v >>> sh;
        // Floor shift rounds negatives down; nudge up by one when bits were lost.
        if (v[FULL_W-1] && ((v & mask) != '0)) r = r + POS_ONE;
        return r;
    endfunction

    function automatic logic signed [FULL_W-1:0] sign_fn(input logic signed [FULL_W-1:0] v);
        return (!v[FULL_W-1] && (v != '0)) ? POS_ONE : NEG_ONE;
    endfunction

    int unsigned              sh_amt;
    logic signed [FULL_W-1:0] shr_i_d, shr_q_d;

    // Clamp the shift so the result is at most the sign, then shift or sign-reduce.
    always_comb begin
        sh_amt = {27'b0, shift_b_q};
        if (sh_amt >= FULL_W-1) sh_amt = FULL_W-1;
        shr_i_d = shr_rtz(mix_i_q, sh_amt);
        shr_q_d = shr_rtz(mix_q_q, sh_amt);
        if (sgn_b_q) begin
            shr_i_d = sign_fn(mix_i_q);
            shr_q_d = sign_fn(mix_q_q);
        end
    end

    logic                     vld_c_q, sgn_c_q;
    logic signed [FULL_W-1:0] shr_i_q, shr_q_q;

    // Shift-stage register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_c_q <= 1'b0;
            sgn_c_q <= 1'b0;
            shr_i_q <= '0;
            shr_q_q <= '0;
        end else begin
            vld_c_q <= vld_b_q;
            sgn_c_q <= sgn_b_q;
            shr_i_q <= shr_i_d;
            shr_q_q <= shr_q_d;
        end
    end

    // ---------------- stage D: symmetric saturation ----------------
    // Returns {clip, value}.
    function automatic logic [OUT_WIDTH:0] sat_fn(input logic signed [FULL_W-1:0] v);
        logic signed [CMP_W-1:0] e;
        e = CMP_W'(v);
        if (e > SAT_MAX)      return {1'b1, SAT_MAX_O};
        else if (e < SAT_MIN) return {1'b1, SAT_MIN_O};
        else                  return {1'b0, OUT_WIDTH'(v)};
    endfunction

    logic [OUT_WIDTH:0] sat_i, sat_q;
    logic               clip_d;

    assign sat_i  = sat_fn(shr_i_q);
    assign sat_q  = sat_fn(shr_q_q);
    assign clip_d = !sgn_c_q && (sat_i[OUT_WIDTH] || sat_q[OUT_WIDTH]);

    logic [OUT_WIDTH-1:0] i_out_q, q_out_q;
    logic                 out_valid_q;

    // Output registers hold their last value across bubbles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_out_q     <= '0;
            q_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= vld_c_q;
            if (vld_c_q) begin
                i_out_q <= sat_i[OUT_WIDTH-1:0];
                q_out_q <= sat_q[OUT_WIDTH-1:0];
            end
        end
    end

    // ---------------- clip statistics ----------------
    logic [PERIOD_2N-1:0] win_q, win_d;
    logic [PERIOD_2N:0]   acc_q, acc_d, acc_inc;
    logic [PERIOD_2N:0]   clip_cnt_q, clip_cnt_d;
    logic                 clip_cnt_vld_q, clip_cnt_vld_d;

    // Window/clip counters advance on valid outputs; the last sample of a window is included in the report.
    always_comb begin
        win_d          = win_q;
        acc_d          = acc_q;
        clip_cnt_d     = clip_cnt_q;
        clip_cnt_vld_d = 1'b0;
        acc_inc        = (clip_d && (acc_q != ACC_MAX)) ? acc_q + 1'b1 : acc_q;
        if (vld_c_q) begin
            if (win_q == WIN_LAST) begin
                clip_cnt_d     = acc_inc;
                clip_cnt_vld_d = 1'b1;
                win_d          = '0;
                acc_d          = '0;
            end else begin
                win_d = win_q + 1'b1;
                acc_d = acc_inc;
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            win_q          <= '0;
            acc_q          <= '0;
            clip_cnt_q     <= '0;
            clip_cnt_vld_q <= 1'b0;
        end else begin
            win_q          <= win_d;
            acc_q          <= acc_d;
            clip_cnt_q     <= clip_cnt_d;
            clip_cnt_vld_q <= clip_cnt_vld_d;
        end
    end

    assign i_out          = i_out_q;
    assign q_out          = q_out_q;
    assign out_valid      = out_valid_q;
    assign clip_cnt       = clip_cnt_q;
    assign clip_cnt_valid = clip_cnt_vld_q;

endmodule
